// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline destination/write-back select stage.
//   PIPE_W       : default datapath width.
//   pipe_state_e : occupancy of the two-entry output buffer.
package pipe_pkg;

  localparam int unsigned PIPE_W = 32;

  // Number of words held: none, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/nway_mux.sv
// Combinational N_SRC:1 W-bit mux with out-of-range select detection.
//   sel  : source index
//   din  : flattened sources, source i at bits [i*W +: W]
//   data : selected source, zero when sel >= N_SRC
//   err  : high when sel >= N_SRC
module nway_mux
  import pipe_pkg::*;
#(
  parameter int unsigned W     = PIPE_W,
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SEL_W = $clog2(N_SRC)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_SRC*W-1:0] din,
  output logic [W-1:0]       data,
  output logic               err
);

  // Any index that matches no source leaves the defaults: zero data, err set.
  always_comb begin
    data = '0;
    err  = 1'b1;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        data = din[i*W +: W];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_dst_mux.sv
// N-way destination/write-back select stage with a registered result and a
// two-entry (main + skid) valid/ready output buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake (in_ready registered)
//   sel, din            : source index and flattened sources, sampled on accept
//   flush               : drop held words and the word offered this cycle
//   out_valid/out_ready : downstream handshake
//   dout, out_sel       : selected data and the select that produced it
//   out_err             : current output word had an out-of-range select
//   sel_err             : sticky out-of-range flag, cleared only by reset
module pipe_dst_mux
  import pipe_pkg::*;
#(
  parameter int unsigned W     = PIPE_W,
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SEL_W = $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_SRC*W-1:0] din,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       dout,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_err,
  output logic               sel_err
);

  pipe_state_e      state, state_n;

  logic [W-1:0]     skid_data, skid_data_n;
  logic [SEL_W-1:0] skid_sel, skid_sel_n;
  logic             skid_err, skid_err_n;

  logic [W-1:0]     main_data_n;
  logic [SEL_W-1:0] main_sel_n;
  logic             main_err_n;
  logic             sel_err_n;

  logic [W-1:0]     mux_data;
  logic             mux_err;
  logic             accept;
  logic             pop;

  nway_mux #(
    .W     (W),
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_mux (
    .sel  (sel),
    .din  (din),
    .data (mux_data),
    .err  (mux_err)
  );

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Next-state and storage-update logic; the main entry drives the outputs.
  always_comb begin
    state_n     = state;
    main_data_n = dout;
    main_sel_n  = out_sel;
    main_err_n  = out_err;
    skid_data_n = skid_data;
    skid_sel_n  = skid_sel;
    skid_err_n  = skid_err;
    sel_err_n   = sel_err;

    if (flush) begin
      // Flush wins over accept and pop; main keeps its stale contents.
      state_n = EMPTY;
    end else begin
      if (accept && mux_err) begin
        sel_err_n = 1'b1;
      end
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_n     = ONE;
            main_data_n = mux_data;
            main_sel_n  = sel;
            main_err_n  = mux_err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data_n = mux_data;
            main_sel_n  = sel;
            main_err_n  = mux_err;
          end else if (accept) begin
            state_n     = TWO;
            skid_data_n = mux_data;
            skid_sel_n  = sel;
            skid_err_n  = mux_err;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_n     = ONE;
            main_data_n = skid_data;
            main_sel_n  = skid_sel;
            main_err_n  = skid_err;
          end
        end
        default: begin
          state_n = EMPTY;
        end
      endcase
    end
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      dout      <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
      sel_err   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      dout      <= main_data_n;
      out_sel   <= main_sel_n;
      out_err   <= main_err_n;
      skid_data <= skid_data_n;
      skid_sel  <= skid_sel_n;
      skid_err  <= skid_err_n;
      sel_err   <= sel_err_n;
      in_ready  <= (state_n != TWO);
      out_valid <= (state_n != EMPTY);
    end
  end

endmodule

// File: tb/tb_pipe_dst_mux.sv
// Bench for pipe_dst_mux: a 4-source and a 3-source instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_pipe_dst_mux;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   sel = 2'd0;
  logic [127:0] din4 = '0;
  logic [95:0]  din3;

  logic         in_ready4, out_valid4, out_err4, sel_err4;
  logic [31:0]  dout4;
  logic [1:0]   out_sel4;
  logic         in_ready3, out_valid3, out_err3, sel_err3;
  logic [31:0]  dout3;
  logic [1:0]   out_sel3;

  word_t        mq4[$];
  word_t        mq3[$];
  logic         serr4 = 1'b0;
  logic         serr3 = 1'b0;
  int           vectors = 0;
  int           miscompares = 0;

  assign din3 = din4[95:0];

  always #5 clk = ~clk;

  pipe_dst_mux #(.W(32), .N_SRC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .sel(sel), .din(din4), .flush(flush), .out_valid(out_valid4),
    .out_ready(out_ready), .dout(dout4), .out_sel(out_sel4),
    .out_err(out_err4), .sel_err(sel_err4)
  );

  pipe_dst_mux #(.W(32), .N_SRC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .sel(sel), .din(din3), .flush(flush), .out_valid(out_valid3),
    .out_ready(out_ready), .dout(dout3), .out_sel(out_sel3),
    .out_err(out_err3), .sel_err(sel_err3)
  );

  // Reference: a FIFO of capacity two; accept when fewer than two are held
  // at the edge, pop when something is held and downstream is ready.
  task automatic model_clock();
    logic  acc, pp;
    word_t w;
    acc = in_valid && (mq4.size() < 2);
    pp  = out_ready && (mq4.size() > 0);
    if (flush) begin
      mq4.delete();
      mq3.delete();
    end else begin
      if (pp) begin
        void'(mq4.pop_front());
        void'(mq3.pop_front());
      end
      if (acc) begin
        w.s = sel;
        w.e = 1'b0;
        w.d = din4[int'(sel)*32 +: 32];
        mq4.push_back(w);
        w.e = (sel >= 2'd3);
        w.d = w.e ? 32'd0 : din4[int'(sel)*32 +: 32];
        mq3.push_back(w);
        if (w.e) serr3 = 1'b1;
      end
    end
  endtask

  function automatic logic [37:0] exp4();
    logic ne, nf;
    ne = (mq4.size() > 0);
    nf = (mq4.size() < 2);
    return {ne, nf, serr4, ne ? mq4[0] : 35'd0};
  endfunction

  function automatic logic [37:0] exp3();
    logic ne, nf;
    ne = (mq3.size() > 0);
    nf = (mq3.size() < 2);
    return {ne, nf, serr3, ne ? mq3[0] : 35'd0};
  endfunction

  function automatic logic [37:0] obs4();
    return {out_valid4, in_ready4, sel_err4,
            out_valid4 ? {dout4, out_sel4, out_err4} : 35'd0};
  endfunction

  function automatic logic [37:0] obs3();
    return {out_valid3, in_ready3, sel_err3,
            out_valid3 ? {dout3, out_sel3, out_err3} : 35'd0};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic step(input logic iv, input logic [1:0] s, input logic fl,
                      input logic ordy);
    in_valid  = iv;
    sel       = s;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({out_valid4, in_ready4, dout4, out_sel4, out_err4, sel_err4} !==
        {1'b0, 1'b1, 32'd0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset4 got ov=%b ir=%b d=%h s=%0d e=%b se=%b want 0 1 0 0 0 0",
               out_valid4, in_ready4, dout4, out_sel4, out_err4, sel_err4);
    end
    vectors++;
    if ({out_valid3, in_ready3, dout3, out_sel3, out_err3, sel_err3} !==
        {1'b0, 1'b1, 32'd0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset3 got ov=%b ir=%b d=%h s=%0d e=%b se=%b want 0 1 0 0 0 0",
               out_valid3, in_ready3, dout3, out_sel3, out_err3, sel_err3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    logic [31:0] pat [4];
    pat[0] = 32'hAAAA_AAAA; pat[1] = 32'hBBBB_BBBB;
    pat[2] = 32'hCCCC_CCCC; pat[3] = 32'hDDDD_DDDD;
    din4 = {pat[3], pat[2], pat[1], pat[0]};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'(k), 1'b0, 1'b1);
      vectors++;
      if (dout4 !== pat[k] || out_valid4 !== 1'b1 || in_ready4 !== 1'b1) begin
        miscompares++;
        $display("FAIL stream%0d got d=%h ov=%b ir=%b want d=%h ov=1 ir=1",
                 k, dout4, out_valid4, in_ready4, pat[k]);
      end
      vectors++;
      if (obs3() !== exp3()) begin
        miscompares++;
        $display("FAIL stream3_%0d got %h want %h", k, obs3(), exp3());
      end
    end
    step(1'b0, 2'd0, 1'b0, 1'b1);
    vectors++;
    if (obs4() !== exp4()) begin
      miscompares++;
      $display("FAIL stream_drain got %h want %h", obs4(), exp4());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w0;
    din4 = {$urandom, $urandom, $urandom, $urandom};
    w0 = din4[63:32];
    step(1'b1, 2'd1, 1'b0, 1'b0);
    din4 = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (in_ready4 !== 1'b0 || dout4 !== w0 || out_sel4 !== 2'd1) begin
        miscompares++;
        $display("FAIL bp_hold%0d got ir=%b d=%h s=%0d want ir=0 d=%h s=1",
                 k, in_ready4, dout4, out_sel4, w0);
      end
      step(1'b1, 2'd0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1);
      vectors++;
      if (obs4() !== exp4()) begin
        miscompares++;
        $display("FAIL bp_drain4_%0d got %h want %h", k, obs4(), exp4());
      end
      vectors++;
      if (obs3() !== exp3()) begin
        miscompares++;
        $display("FAIL bp_drain3_%0d got %h want %h", k, obs3(), exp3());
      end
    end
  endtask

  task automatic test_flush_two();
    din4 = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 1'b0);
    vectors++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 ||
        out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_two got ov4=%b ir4=%b ov3=%b ir3=%b want 0 1 0 1",
               out_valid4, in_ready4, out_valid3, in_ready3);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1);
      vectors++;
      if (obs4() !== exp4() || obs3() !== exp3()) begin
        miscompares++;
        $display("FAIL flush_after%0d got %h/%h want %h/%h",
                 k, obs4(), obs3(), exp4(), exp3());
      end
    end
  endtask

  task automatic test_out_of_range();
    din4 = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 2'd3, 1'b0, 1'b0);
    vectors++;
    if (dout3 !== 32'd0 || out_err3 !== 1'b1 || sel_err3 !== 1'b1 ||
        out_valid3 !== 1'b1 || out_sel3 !== 2'd3) begin
      miscompares++;
      $display("FAIL oor_word got d=%h e=%b se=%b ov=%b s=%0d want 0 1 1 1 3",
               dout3, out_err3, sel_err3, out_valid3, out_sel3);
    end
    vectors++;
    if (out_err4 !== 1'b0 || sel_err4 !== 1'b0 || dout4 !== din4[127:96]) begin
      miscompares++;
      $display("FAIL oor_n4 got e=%b se=%b d=%h want 0 0 %h",
               out_err4, sel_err4, dout4, din4[127:96]);
    end
    step(1'b0, 2'd0, 1'b1, 1'b1);
    step(1'b1, 2'd0, 1'b0, 1'b1);
    vectors++;
    if (sel_err3 !== 1'b1 || out_err3 !== 1'b0 || dout3 !== din4[31:0]) begin
      miscompares++;
      $display("FAIL oor_sticky got se=%b e=%b d=%h want 1 0 %h",
               sel_err3, out_err3, dout3, din4[31:0]);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1);
    vectors++;
    if (obs3() !== exp3()) begin
      miscompares++;
      $display("FAIL oor_drain got %h want %h", obs3(), exp3());
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    din4 = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    mq4.delete();
    mq3.delete();
    serr3 = 1'b0;
    serr4 = 1'b0;
    vectors++;
    if (out_valid4 !== 1'b0 || dout4 !== 32'd0 || in_ready4 !== 1'b1 ||
        out_valid3 !== 1'b0 || dout3 !== 32'd0 || sel_err3 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst got ov4=%b d4=%h ir4=%b ov3=%b d3=%h se3=%b want 0 0 1 0 0 0",
               out_valid4, dout4, in_ready4, out_valid3, dout3, sel_err3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    din4 = {$urandom, $urandom, $urandom, $urandom};
    w = din4[95:64];
    step(1'b1, 2'd2, 1'b0, 1'b1);
    vectors++;
    if (out_valid4 !== 1'b1 || dout4 !== w || out_valid3 !== 1'b1 || dout3 !== w) begin
      miscompares++;
      $display("FAIL post_rst got ov4=%b d4=%h ov3=%b d3=%h want 1 %h",
               out_valid4, dout4, out_valid3, dout3, w);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_accept_pop();
    for (int k = 0; k < 10; k++) begin
      din4 = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, 2'(k % 2), 1'b0, (k % 2) == 0);
      vectors++;
      if (obs4() !== exp4()) begin
        miscompares++;
        $display("FAIL ap4_%0d got %h want %h", k, obs4(), exp4());
      end
      vectors++;
      if (obs3() !== exp3()) begin
        miscompares++;
        $display("FAIL ap3_%0d got %h want %h", k, obs3(), exp3());
      end
    end
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      din4 = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(9, 0) < 7, 2'($urandom_range(3, 0)),
           $urandom_range(15, 0) == 0, $urandom_range(9, 0) < 6);
      vectors++;
      if (obs4() !== exp4()) begin
        miscompares++;
        $display("FAIL rand4_%0d got %h want %h", k, obs4(), exp4());
      end
      vectors++;
      if (obs3() !== exp3()) begin
        miscompares++;
        $display("FAIL rand3_%0d got %h want %h", k, obs3(), exp3());
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_out_of_range();
    test_async_reset();
    test_accept_pop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_dst_mux.md
Name: pipe_dst_mux

Overview:
- Parametrised N-way destination/write-back select stage for the MIPS pipeline.
- Selects one of N_SRC W-bit sources with a binary select and registers the result.
- Presents the result through a valid/ready handshake with a 2-entry skid buffer, so backpressure from the next stage never drops data.
- Supports pipeline flush and flags out-of-range selects.

Parameters:
- W, 32, data width of each source and of the output.
- N_SRC, 4, number of selectable sources (2 or more).
- SEL_W, $clog2(N_SRC), select width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept a word this cycle.
- sel  input  SEL_W  source index, sampled on accept.
- din  input  N_SRC*W  flattened sources; source i occupies bits [i*W +: W].
- flush  input  1  discard all held words and any word offered this cycle.
- out_valid  output  1  dout/out_sel valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- dout  output  W  selected data.
- out_sel  output  SEL_W  select that produced dout.
- out_err  output  1  the current output word had sel >= N_SRC.
- sel_err  output  1  sticky: an out-of-range select was ever accepted.

Behaviour:
- Reset (async assert, sync release): out_valid=0, dout=0, out_sel=0, out_err=0, sel_err=0, in_ready=1, state EMPTY, skid entry cleared.
- Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Mux:
  - sel < N_SRC: data = din[sel*W +: W].
  - sel >= N_SRC (only possible when N_SRC is not a power of 2): data = 0, err = 1, and sel_err sets.
- Latency: a word accepted into EMPTY appears on dout the next cycle (1 cycle).
- Two storage entries: main (drives outputs) and skid.
- States:
  - EMPTY: accept -> ONE (main loaded).
  - ONE:
    - accept and pop -> ONE (main reloaded).
    - accept only -> TWO (new word into skid).
    - pop only -> EMPTY.
    - neither -> ONE.
  - TWO:
    - pop -> ONE (skid moves to main).
    - no pop -> TWO.
    - No accept in TWO.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. It must not depend combinationally on out_ready.
- out_valid = 1 in ONE/TWO.
- Ordering is strict FIFO; words are never duplicated or reordered.
- Held words: dout/out_sel/out_err stay stable while out_valid && !out_ready.
- Flush:
  - Has priority over accept and pop in the same cycle.
  - Next state EMPTY, out_valid=0, in_ready=1.
  - The word offered that cycle is dropped and does not update sel_err.
  - dout keeps its last value; it is don't-care while out_valid=0.
- sel_err: cleared only by rst_n; flush does not clear it.
- Reset asserted mid-transfer: all held words are lost and outputs return to reset values immediately (asynchronous).
- Inputs are not sampled while rst_n=0.

Decomposition:
- Shared package pipe_pkg:
  - state encoding typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
  - Default W=32 constant.
- One sub-module: nway_mux, combinational N_SRC:1 W-bit mux with out-of-range detect (outputs data, err).
- The state machine and storage stay in pipe_dst_mux.

Test Plan:
1. Streaming: N_SRC=4, out_ready=1, din={4'hD..,C..,B..,A..} (src3..src0 = 32'hDDDD_DDDD..32'hAAAA_AAAA), sel=0,1,2,3 on consecutive cycles -> dout AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD on cycles 1-4; in_ready stays 1.
2. Backpressure: out_ready=0, present words W0 (sel=1) then W1 (sel=2) -> in_ready drops to 0 after the second accept; dout holds W0. Raise out_ready -> W0, then W1, in order; in_ready returns to 1 the cycle after the first pop.
3. Flush in TWO: with both entries full and in_valid=1, pulse flush -> next cycle out_valid=0 and in_ready=1; the flushed and offered words never appear on dout.
4. Out-of-range select: N_SRC=3, sel=3 -> dout=0 and out_err=1 for that word; sel_err=1 and stays 1 after a later flush and a valid word; cleared only by rst_n.
5. Async reset: assert rst_n=0 mid-cycle while in TWO -> out_valid=0, dout=0, sel_err=0 immediately, without waiting for a clock edge; after release, first accept appears after 1 cycle.
6. Simultaneous accept and pop in ONE: alternate sel 0/1 for 10 cycles with out_ready toggling 1,0,1,... -> every accepted word is output exactly once, in order, with no bubble while out_ready=1.
